// File: rtl/activation_lut_pkg.sv
// rtl/activation_lut_pkg.sv - shared constants and table-entry helpers for the activation LUT
package activation_lut_pkg;

  // Function selection codes, carried as fixed-width vectors so comparisons stay width-clean
  localparam logic [63:0] ACT_FN_RELU    = 64'("RELU");
  localparam logic [63:0] ACT_FN_SIGMOID = 64'("SIGMOID");

  // Neuron datapath defaults
  localparam int ACT_FN_SIZE   = 5;
  localparam int IP_DATA_WIDTH = 8;
  localparam int DEF_IN_FRAC   = 2;
  localparam int DEF_OUT_FRAC  = 6;

  // ReLU of a signed code: rescale from IN_FRAC to OUT_FRAC fractional bits, clamp to max positive
  function automatic int relu_entry(int code, int in_frac, int out_frac, int data_width);
    longint v;
    longint sat;
    sat = (longint'(1) << (data_width - 1)) - 1;
    if (code <= 0) begin
      return 0;
    end
    if (out_frac >= in_frac) begin
      v = longint'(code) << (out_frac - in_frac);
    end else begin
      v = longint'(code) >>> (in_frac - out_frac);
    end
    if (v > sat) begin
      v = sat;
    end
    return int'(v);
  endfunction

  // Piecewise-linear sigmoid of a signed code, exact in fixed point.
  // Every segment is evaluated in units of 1/(32 * 2^in_frac) so all slopes and
  // offsets become integers; the final division rounds to nearest with ties up.
  function automatic int sigmoid_entry(int code, int in_frac, int out_frac);
    longint a_fix;
    longint one;
    longint num;
    longint p;
    a_fix = (code < 0) ? -longint'(code) : longint'(code);
    one   = longint'(1) << in_frac;
    if (a_fix < one) begin
      num = 8 * a_fix + 16 * one;
    end else if (8 * a_fix < 19 * one) begin
      num = 4 * a_fix + 20 * one;
    end else if (a_fix < 5 * one) begin
      num = a_fix + 27 * one;
    end else begin
      num = 32 * one;
    end
    p = ((num << out_frac) + 16 * one) >>> (in_frac + 5);
    if (code < 0) begin
      return int'((longint'(1) << out_frac) - p);
    end
    return int'(p);
  endfunction

endpackage

// File: rtl/activation_lut_if.sv
// rtl/activation_lut_if.sv - index/value bus between the neuron and the activation core
interface activation_lut_if
  import activation_lut_pkg::*;
#(
  parameter int MEM_WIDTH  = ACT_FN_SIZE,
  parameter int DATA_WIDTH = IP_DATA_WIDTH
);

  logic [MEM_WIDTH-1:0]  idx;
  logic [DATA_WIDTH-1:0] val;

  modport master (output idx, input val);
  modport slave  (input idx, output val);

endinterface

// File: rtl/activation_lut_core.sv
// rtl/activation_lut_core.sv - elaboration-time table, ROM lookup and output register
module activation_lut_core
  import activation_lut_pkg::*;
#(
  parameter int          MEM_WIDTH  = ACT_FN_SIZE,
  parameter int          DATA_WIDTH = IP_DATA_WIDTH,
  parameter logic [63:0] ACT_FN     = ACT_FN_RELU,
  parameter int          IN_FRAC    = DEF_IN_FRAC,
  parameter int          OUT_FRAC   = DEF_OUT_FRAC
) (
  input logic              i_clk,
  input logic              i_rst_n,
  activation_lut_if.slave  bus
);

  localparam int DEPTH      = 1 << MEM_WIDTH;
  localparam bit IS_SIGMOID = (ACT_FN == ACT_FN_SIGMOID);

  if (MEM_WIDTH < 2) begin : g_err_mem_width
    $error("activation_lut: MEM_WIDTH must be at least 2");
  end
  if ((ACT_FN != ACT_FN_RELU) && (ACT_FN != ACT_FN_SIGMOID)) begin : g_err_act_fn
    $error("activation_lut: ACT_FN must be RELU or SIGMOID");
  end
  if (IS_SIGMOID && (OUT_FRAC > DATA_WIDTH - 2)) begin : g_err_out_frac
    $error("activation_lut: SIGMOID needs OUT_FRAC <= DATA_WIDTH-2 so 1.0 fits");
  end

  // Packed table, entry u sits at bits [u*DATA_WIDTH +: DATA_WIDTH]; u is the raw index code
  function automatic logic [DEPTH*DATA_WIDTH-1:0] build_table();
    logic [DEPTH*DATA_WIDTH-1:0] t;
    int sv;
    int e;
    t = '0;
    for (int u = 0; u < DEPTH; u++) begin
      sv = (u >= DEPTH / 2) ? u - DEPTH : u;
      if (IS_SIGMOID) begin
        e = sigmoid_entry(sv, IN_FRAC, OUT_FRAC);
      end else begin
        e = relu_entry(sv, IN_FRAC, OUT_FRAC, DATA_WIDTH);
      end
      t[u*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(e);
    end
    return t;
  endfunction

  localparam logic [DEPTH*DATA_WIDTH-1:0] ROM_IMAGE = build_table();

  logic [DATA_WIDTH-1:0] w_rom [DEPTH];
  bit   [DATA_WIDTH-1:0] r_mem_out;

  for (genvar g = 0; g < DEPTH; g++) begin : g_rom
    assign w_rom[g] = ROM_IMAGE[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // Register the looked-up entry; reset forces zero and ignores the index on that edge
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_mem_out <= '0;
    end else begin
      r_mem_out <= w_rom[bus.idx];
    end
  end

  assign bus.val = r_mem_out;

endmodule

// File: rtl/activation_lut_wrappers.sv
// rtl/activation_lut_wrappers.sv - fixed-function ReLU and sigmoid wrappers for the neuron
module relu_func
  import activation_lut_pkg::*;
#(
  parameter int MEM_WIDTH  = ACT_FN_SIZE,
  parameter int DATA_WIDTH = IP_DATA_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic signed [MEM_WIDTH-1:0]  in,
  output logic signed [DATA_WIDTH-1:0] mem_out
);

  activation_lut #(
    .MEM_WIDTH (MEM_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .ACT_FN    (ACT_FN_RELU)
  ) u_lut (
    .clk    (clk),
    .rst    (rst),
    .in     (in),
    .mem_out(mem_out)
  );

endmodule

module sigmoid_func
  import activation_lut_pkg::*;
#(
  parameter int MEM_WIDTH  = ACT_FN_SIZE,
  parameter int DATA_WIDTH = IP_DATA_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic signed [MEM_WIDTH-1:0]  in,
  output logic signed [DATA_WIDTH-1:0] mem_out
);

  activation_lut #(
    .MEM_WIDTH (MEM_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .ACT_FN    (ACT_FN_SIGMOID)
  ) u_lut (
    .clk    (clk),
    .rst    (rst),
    .in     (in),
    .mem_out(mem_out)
  );

endmodule

// File: rtl/activation_lut.sv
// rtl/activation_lut.sv - registered LUT activation unit (ReLU or piecewise-linear sigmoid)
module activation_lut
  import activation_lut_pkg::*;
#(
  parameter int          MEM_WIDTH  = ACT_FN_SIZE,
  parameter int          DATA_WIDTH = IP_DATA_WIDTH,
  parameter logic [63:0] ACT_FN     = ACT_FN_RELU,
  parameter int          IN_FRAC    = DEF_IN_FRAC,
  parameter int          OUT_FRAC   = DEF_OUT_FRAC
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic signed [MEM_WIDTH-1:0]  in,
  output logic signed [DATA_WIDTH-1:0] mem_out
);

  activation_lut_if #(.MEM_WIDTH(MEM_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_bus ();

  assign u_bus.idx = in;
  assign mem_out   = u_bus.val;

  activation_lut_core #(
    .MEM_WIDTH (MEM_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .ACT_FN    (ACT_FN),
    .IN_FRAC   (IN_FRAC),
    .OUT_FRAC  (OUT_FRAC)
  ) u_core (
    .i_clk  (clk),
    .i_rst_n(rst),
    .bus    (u_bus.slave)
  );

endmodule

// File: tb/tb_activation_lut.sv
// tb/tb_activation_lut.sv - self-checking bench for activation_lut and its wrappers
module tb_activation_lut;
  import activation_lut_pkg::*;

  localparam int MW = ACT_FN_SIZE;
  localparam int DW = IP_DATA_WIDTH;

  logic clk = 1'b0;
  logic rst;
  logic signed [DW-1:0] sig_out;
  logic signed [DW-1:0] rf_out;

  always #5 clk = ~clk;

  activation_lut_if #(.MEM_WIDTH(MW), .DATA_WIDTH(DW)) tb_bus ();

  activation_lut dut_relu (.clk(clk), .rst(rst), .in(tb_bus.idx), .mem_out(tb_bus.val));
  sigmoid_func   dut_sig  (.clk(clk), .rst(rst), .in(tb_bus.idx), .mem_out(sig_out));
  relu_func      dut_rf   (.clk(clk), .rst(rst), .in(tb_bus.idx), .mem_out(rf_out));

  int total = 0;
  int bad   = 0;

  typedef struct {
    int idx;
    bit sig;
    int exp;
  } vec_t;

  vec_t vecs[16];
  int   tab[32];
  int   seq[4];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int relu_ref(input int i);
    real v;
    int  top;
    top = (1 << (DW - 1)) - 1;
    if (i <= 0) return 0;
    v = $floor(real'(i) * (2.0 ** real'(DEF_OUT_FRAC - DEF_IN_FRAC)));
    if (v > real'(top)) return top;
    return int'(v);
  endfunction

  function automatic int sig_ref(input int i);
    real a;
    real f;
    int  p;
    a = real'((i < 0) ? -i : i) / (2.0 ** real'(DEF_IN_FRAC));
    if (a < 1.0)        f = 0.25 * a + 0.5;
    else if (a < 2.375) f = 0.125 * a + 0.625;
    else if (a < 5.0)   f = 0.03125 * a + 0.84375;
    else                f = 1.0;
    p = int'($floor(f * (2.0 ** real'(DEF_OUT_FRAC)) + 0.5));
    return (i < 0) ? (1 << DEF_OUT_FRAC) - p : p;
  endfunction

  function automatic int relu_now();
    return int'($signed(tb_bus.val));
  endfunction

  initial begin
    vecs[0]  = '{-16, 1'b0, 0};
    vecs[1]  = '{-3,  1'b0, 0};
    vecs[2]  = '{0,   1'b0, 0};
    vecs[3]  = '{1,   1'b0, 16};
    vecs[4]  = '{7,   1'b0, 112};
    vecs[5]  = '{8,   1'b0, 127};
    vecs[6]  = '{15,  1'b0, 127};
    vecs[7]  = '{0,   1'b1, 32};
    vecs[8]  = '{1,   1'b1, 36};
    vecs[9]  = '{4,   1'b1, 48};
    vecs[10] = '{6,   1'b1, 52};
    vecs[11] = '{10,  1'b1, 59};
    vecs[12] = '{15,  1'b1, 62};
    vecs[13] = '{-4,  1'b1, 16};
    vecs[14] = '{-15, 1'b1, 2};
    vecs[15] = '{-16, 1'b1, 2};
    seq[0] = 0;
    seq[1] = 15;
    seq[2] = -16;
    seq[3] = 7;

    rst = 1'b0;
    tb_bus.idx = MW'(15);
    #1;
    chk("pre_edge_relu", relu_now(), 0);
    chk("pre_edge_sig", int'(sig_out), 0);

    for (int k = 0; k < 3; k++) begin
      tick();
      chk("reset_relu", relu_now(), 0);
      chk("reset_sig", int'(sig_out), 0);
    end
    rst = 1'b1;
    tick();
    chk("release_relu", relu_now(), 127);
    chk("release_sig", int'(sig_out), 62);

    for (int v = 0; v < 16; v++) begin
      tb_bus.idx = MW'(vecs[v].idx);
      tick();
      if (vecs[v].sig) chk("vec_sig", int'(sig_out), vecs[v].exp);
      else             chk("vec_relu", relu_now(), vecs[v].exp);
    end

    for (int i = -16; i < 16; i++) begin
      tb_bus.idx = MW'(i);
      tick();
      tab[i + 16] = int'(sig_out);
      chk("sig_range", int'(tab[i + 16] >= 0 && tab[i + 16] <= 64), 1);
    end
    for (int i = 1; i < 16; i++) begin
      chk("sig_symmetry", tab[i + 16] + tab[16 - i], 64);
    end

    for (int k = 0; k < 4; k++) begin
      tb_bus.idx = MW'(seq[k]);
      tick();
      chk("b2b_relu", relu_now(), relu_ref(seq[k]));
      chk("b2b_sig", int'(sig_out), sig_ref(seq[k]));
    end

    tb_bus.idx = MW'(15);
    tick();
    chk("mid_pre_relu", relu_now(), 127);
    rst = 1'b0;
    tb_bus.idx = MW'(7);
    tick();
    chk("mid_rst_relu", relu_now(), 0);
    chk("mid_rst_sig", int'(sig_out), 0);
    rst = 1'b1;
    tb_bus.idx = MW'(-4);
    tick();
    chk("mid_post_relu", relu_now(), 0);
    chk("mid_post_sig", int'(sig_out), 16);
    tb_bus.idx = MW'(1);
    tick();
    chk("mid_next_relu", relu_now(), 16);
    chk("mid_next_sig", int'(sig_out), 36);

    for (int n = 0; n < 300; n++) begin
      int  i;
      bit  run;
      run = ($urandom_range(0, 9) != 0);
      i   = int'($urandom_range(0, 31)) - 16;
      rst = run;
      tb_bus.idx = MW'(i);
      tick();
      chk("rand_relu", relu_now(), run ? relu_ref(i) : 0);
      chk("rand_sig", int'(sig_out), run ? sig_ref(i) : 0);
      chk("rand_relu_func", int'(rf_out), run ? relu_ref(i) : 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
